// File: rtl/demux_3b_1to4_seq.sv
// rtl/demux_3b_1to4_seq.sv - sequential 1-to-4 demultiplexer for a time-division link
//
// Each enabled clock writes one W-bit word into one of four registered
// channels (a..d = slots 0..3). The slot comes from an internal counter that
// a frame sync marker realigns to slot 0. A mid-frame sync sets a sticky
// error flag.
//
// Optional feature macro: DEMUX_EXT_SEL_EN
//   defined   - slot is taken from the external se port, the counter and
//               sync handling are dropped, sync_err is constant 0, and slot
//               reports the last written se.
//   undefined - counter-driven slot selection, no se port.

module demux_3b_1to4_seq #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         sync,
   input  logic [W-1:0] din,
`ifdef DEMUX_EXT_SEL_EN
   input  logic [1:0]   se,
`endif
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic [W-1:0] c,
   output logic [W-1:0] d,
   output logic [3:0]   vld,
   output logic [1:0]   slot,
   output logic         frame_done,
   output logic         sync_err
);

   // Channel storage, indexed by slot number.
   logic [W-1:0] ch_q [4];
   logic [W-1:0] ch_d [4];

   // Slot pointer: the frame counter, or the last written se in
   // external-select builds. Either way it is what slot reports.
   logic [1:0]   ptr_q;
   logic [1:0]   ptr_d;

   logic [3:0]   vld_q;
   logic [3:0]   vld_d;
   logic         frame_done_q;
   logic         frame_done_d;
   logic         sync_err_q;
   logic         sync_err_d;

   // Effective slot for the current word, the pointer value after a write,
   // and whether this word's sync arrived mid-frame.
   logic [1:0]   s;
   logic [1:0]   ptr_adv;
   logic         sync_mid;

`ifdef DEMUX_EXT_SEL_EN
   // sync carries no meaning when the slot is chosen externally.
   logic         unused_sync;
   assign unused_sync = sync;

   assign s        = se;
   assign ptr_adv  = se;
   assign sync_mid = 1'b0;
`else
   // A sync word always belongs to slot 0. It realigns the counter and is
   // an error only when the counter was not already at a frame boundary.
   assign s        = sync ? 2'd0 : ptr_q;
   assign ptr_adv  = s + 2'd1;
   assign sync_mid = sync && (ptr_q != 2'd0);
`endif

   // Next-state: steer the word into its channel and strobe vld/frame_done
   // on enabled cycles. Idle cycles only drop the strobes.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         ch_d[i] = ch_q[i];
      end
      ptr_d        = ptr_q;
      vld_d        = 4'b0000;
      frame_done_d = 1'b0;
      sync_err_d   = sync_err_q;
      if (en) begin
         ch_d[s]      = din;
         vld_d        = 4'b0001 << s;
         ptr_d        = ptr_adv;
         frame_done_d = (s == 2'd3);
         sync_err_d   = sync_err_q | sync_mid;
      end
   end

   // State registers with asynchronous clear so a mid-frame reset empties
   // the outputs without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            ch_q[i] <= '0;
         end
         ptr_q        <= 2'd0;
         vld_q        <= 4'b0000;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            ch_q[i] <= ch_d[i];
         end
         ptr_q        <= ptr_d;
         vld_q        <= vld_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   // Outputs are direct register reads. slot ignores the live sync input.
   always_comb begin
      a          = ch_q[0];
      b          = ch_q[1];
      c          = ch_q[2];
      d          = ch_q[3];
      vld        = vld_q;
      slot       = ptr_q;
      frame_done = frame_done_q;
      sync_err   = sync_err_q;
   end

endmodule

// File: tb/tb_demux_3b_1to4_seq.sv
// tb/tb_demux_3b_1to4_seq.sv - scoreboard bench for demux_3b_1to4_seq

module tb_demux_3b_1to4_seq;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       sync;
   logic [2:0] din;
`ifdef DEMUX_EXT_SEL_EN
   logic [1:0] se;
`endif
   logic [2:0] a, b, c, d;
   logic [3:0] vld;
   logic [1:0] slot;
   logic       frame_done;
   logic       sync_err;

   demux_3b_1to4_seq #(.W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .sync       (sync),
      .din        (din),
`ifdef DEMUX_EXT_SEL_EN
      .se         (se),
`endif
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .vld        (vld),
      .slot       (slot),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [2:0] data;
      logic       fd;
      logic [1:0] sel;
   } item_t;

   item_t      exp_q[$];

   // Reference state: channel contents, slot pointer and sticky error.
   logic [2:0] m_ch [4];
   int         m_cnt;
   int         m_slot;
   logic       m_err;

   int         errors = 0;
   int         checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_ch[i] = 3'd0;
      m_cnt  = 0;
      m_slot = 0;
      m_err  = 1'b0;
   endtask

   // Drive one clock's inputs on the falling edge and advance the model to
   // the state the DUT must show after the following rising edge.
   task automatic step(input logic e, input logic sy, input logic [2:0] dn, input logic [1:0] sel);
      item_t it;
      int    idx;
      @(negedge clk);
      en   = e;
      sync = sy;
      din  = dn;
`ifdef DEMUX_EXT_SEL_EN
      se   = sel;
`endif
      if (e) begin
`ifdef DEMUX_EXT_SEL_EN
         idx    = int'(sel);
         m_slot = idx;
`else
         idx = sy ? 0 : m_cnt;
         if (sy && m_cnt != 0) m_err = 1'b1;
         m_cnt  = (idx + 1) % 4;
         m_slot = m_cnt;
`endif
         m_ch[idx] = dn;
         it.idx  = idx;
         it.data = dn;
         it.fd   = (idx == 3);
         it.sel  = sel;
         exp_q.push_back(it);
      end
   endtask

   task automatic idle_then_settle();
      step(1'b0, 1'b0, 3'd0, 2'd0);
      @(posedge clk);
      #2;
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic rst_pulse(input string tag);
      @(negedge clk);
      en   = 1'b0;
      sync = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk({tag, "_a"}, a, 0);
      chk({tag, "_b"}, b, 0);
      chk({tag, "_c"}, c, 0);
      chk({tag, "_d"}, d, 0);
      chk({tag, "_vld"}, vld, 0);
      chk({tag, "_slot"}, slot, 0);
      chk({tag, "_fd"}, frame_done, 0);
      chk({tag, "_err"}, sync_err, 0);
      model_reset();
      exp_q.delete();
      #1 rst_n = 1'b1;
   endtask

   // Monitor: pop an expected write whenever the DUT strobes vld; on quiet
   // cycles confirm nothing was owed. Every cycle compare the visible state.
   initial begin
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (vld !== 4'b0000) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_vld", vld, 0);
            end else begin
               it = exp_q.pop_front();
               chk($sformatf("vld_slot%0d_sel%0d", it.idx, it.sel), vld, 32'd1 << it.idx);
               chk($sformatf("frame_done_slot%0d", it.idx), frame_done, it.fd);
            end
         end else begin
            chk("idle_frame_done", frame_done, 0);
            if (exp_q.size() != 0) begin
               it = exp_q.pop_front();
               chk($sformatf("missing_write_slot%0d", it.idx), vld, 32'd1 << it.idx);
            end
         end
         chk("ch_a", a, m_ch[0]);
         chk("ch_b", b, m_ch[1]);
         chk("ch_c", c, m_ch[2]);
         chk("ch_d", d, m_ch[3]);
         chk("slot", slot, m_slot);
         chk("sync_err", sync_err, m_err);
      end
   end

   initial begin
      logic [1:0] slot_before;
      int         r;
      en    = 1'b0;
      sync  = 1'b0;
      din   = 3'd0;
`ifdef DEMUX_EXT_SEL_EN
      se    = 2'd0;
`endif
      rst_n = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      #20 rst_n = 1'b1;
      #1;
      chk("reset_vld", vld, 0);
      chk("reset_slot", slot, 0);
      chk("reset_err", sync_err, 0);
      chk("reset_a", a, 0);

`ifdef DEMUX_EXT_SEL_EN
      step(1'b1, 1'b0, 3'b110, 2'b10);
      step(1'b1, 1'b0, 3'b001, 2'b00);
      step(1'b1, 1'b1, 3'b100, 2'b11);
      idle_then_settle();
      chk("ext_c", c, 3'b110);
      chk("ext_a", a, 3'b001);
      chk("ext_d", d, 3'b100);
      chk("ext_err", sync_err, 0);
      chk("ext_slot", slot, 2'd3);
`else
      // Plain frame aligned by sync.
      step(1'b1, 1'b1, 3'b000, 2'd0);
      step(1'b1, 1'b0, 3'b001, 2'd0);
      step(1'b1, 1'b0, 3'b010, 2'd0);
      step(1'b1, 1'b0, 3'b011, 2'd0);
      idle_then_settle();
      chk("f1_a", a, 3'b000);
      chk("f1_b", b, 3'b001);
      chk("f1_c", c, 3'b010);
      chk("f1_d", d, 3'b011);
      chk("f1_slot", slot, 2'd0);

      // Same frame with a two-cycle en gap after the second word.
      rst_pulse("rst1");
      step(1'b1, 1'b1, 3'b000, 2'd0);
      step(1'b1, 1'b0, 3'b001, 2'd0);
      step(1'b0, 1'b0, 3'b111, 2'd0);
      step(1'b0, 1'b0, 3'b111, 2'd0);
      step(1'b1, 1'b0, 3'b010, 2'd0);
      step(1'b1, 1'b0, 3'b011, 2'd0);
      idle_then_settle();
      chk("gap_c", c, 3'b010);
      chk("gap_d", d, 3'b011);
      chk("gap_err", sync_err, 0);

      // Back-to-back frame start, then a mid-frame sync at slot 2.
      step(1'b1, 1'b1, 3'b101, 2'd0);
      step(1'b1, 1'b0, 3'b110, 2'd0);
      step(1'b1, 1'b1, 3'b111, 2'd0);
      step(1'b1, 1'b0, 3'b100, 2'd0);
      idle_then_settle();
      chk("serr_a", a, 3'b111);
      chk("serr_b", b, 3'b100);
      chk("serr_flag", sync_err, 1);
      step(1'b1, 1'b1, 3'b010, 2'd0);
      idle_then_settle();
      chk("serr_sticky", sync_err, 1);

      // Reset mid-frame with non-zero channels, then a fresh word lands in a.
      step(1'b1, 1'b0, 3'b011, 2'd0);
      step(1'b1, 1'b0, 3'b110, 2'd0);
      rst_pulse("rst_mid");
      step(1'b1, 1'b0, 3'b011, 2'd0);
      idle_then_settle();
      chk("post_rst_a", a, 3'b011);

      // sync with en low is ignored.
      slot_before = slot;
      step(1'b0, 1'b1, 3'b101, 2'd0);
      idle_then_settle();
      chk("en0_slot", slot, slot_before);
      chk("en0_a", a, 3'b011);
      chk("en0_err", sync_err, 0);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r == 0) begin
            rst_pulse("rst_rand");
         end else begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)));
         end
      end
      idle_then_settle();
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
